tpm_axil_resp_mem: RTL and testbench

AXI4-Lite responder (slave) that terminates the M00_AXI initiator port of the TPM IP, serving as a small word-addressed register memory. It accepts write address/data on independent channels, applies byte strobes, answers reads from the same storage and signals SLVERR for out-of-range addresses. It replaces the slave VIP in the BFM design for RTL-only loopback runs, and sits on-chip as a scratch target for the initiator.

---
 rtl/tpm_axil_resp_mem_if.sv | 51 +++++
 rtl/tpm_axil_resp_mem.sv | 201 ++++++++++++++++++++
 tb/tb_tpm_axil_resp_mem.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_axil_resp_mem_if.sv
// AXI4-Lite bus bundle between the TPM M00_AXI initiator and its responder.
// Signals:
//   AW channel : AWADDR, AWPROT, AWVALID (master) / AWREADY (slave)
//   W channel  : WDATA, WSTRB, WVALID (master) / WREADY (slave)
//   B channel  : BRESP, BVALID (slave) / BREADY (master)
//   AR channel : ARADDR, ARPROT, ARVALID (master) / ARREADY (slave)
//   R channel  : RDATA, RRESP, RVALID (slave) / RREADY (master)
interface tpm_axil_resp_mem_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID,    input WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input RREADY
  );
endinterface

// File: rtl/tpm_axil_resp_mem.sv
// AXI4-Lite responder terminating the TPM M00_AXI initiator: a small
// word-addressed register memory with byte strobes and SLVERR on
// out-of-range word indices.
// Ports:
//   ACLK      - single clock, rising edge
//   ARESET    - asynchronous active-high reset
//   bus       - AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   err_count - saturating count of SLVERR responses (reads + writes)
//
// Write FSM
//   state     | meaning
//   W_IDLE    | nothing held, AWREADY and WREADY high
//   W_HAVE_AW | address held, waiting for data
//   W_HAVE_W  | data and strobe held, waiting for address
//   W_RESP    | BVALID high, waiting for BREADY
// Read FSM
//   state     | meaning
//   R_IDLE    | ARREADY high
//   R_DATA    | RVALID high, waiting for RREADY
module tpm_axil_resp_mem #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  tpm_axil_resp_mem_if.slave bus,
  output logic [7:0]         err_count
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;

  w_state_t              w_state;
  logic [IDX_W-1:0]      hold_idx;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [STRB_W-1:0]     hold_strb;
  logic                  bvalid;
  logic [1:0]            bresp;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  c_ok;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;

  // Readies depend on registered state only; ARESET forces them low.
  assign bus.AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign bus.WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_AW);

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;

  // The commit uses whichever half was captured earlier and the live bus for
  // the half arriving now.
  always_comb begin
    c_idx  = (w_state == W_HAVE_AW) ? hold_idx  : bus.AWADDR[ADDR_WIDTH-1:2];
    c_data = (w_state == W_HAVE_W)  ? hold_data : bus.WDATA;
    c_strb = (w_state == W_HAVE_W)  ? hold_strb : bus.WSTRB;
    commit = 1'b0;
    case (w_state)
      W_IDLE:    commit = aw_hs && w_hs;
      W_HAVE_AW: commit = w_hs;
      W_HAVE_W:  commit = aw_hs;
      default:   commit = 1'b0;
    endcase
    c_ok = idx_ok(c_idx);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      hold_idx  <= '0;
      hold_data <= '0;
      hold_strb <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      w_state <= W_RESP;
      bvalid  <= 1'b1;
      bresp   <= c_ok ? RESP_OKAY : RESP_SLVERR;
      if (c_ok) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (c_strb[b]) begin
            mem[c_idx[MEM_AW-1:0]][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            hold_idx <= bus.AWADDR[ADDR_WIDTH-1:2];
            w_state  <= W_HAVE_AW;
          end else if (w_hs) begin
            hold_data <= bus.WDATA;
            hold_strb <= bus.WSTRB;
            w_state   <= W_HAVE_W;
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BVALID = bvalid;
  assign bus.BRESP  = bresp;

  // ----------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t              r_state;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  ar_hs;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_ok;

  assign bus.ARREADY = !ARESET && (r_state == R_IDLE);
  assign ar_hs       = bus.ARVALID && bus.ARREADY;
  assign r_idx       = bus.ARADDR[ADDR_WIDTH-1:2];
  assign r_ok        = idx_ok(r_idx);

  // mem is sampled before the write block's non-blocking update lands, so a
  // same-edge commit to the same word returns the old contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= r_ok ? mem[r_idx[MEM_AW-1:0]] : '0;
            rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.RREADY) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.RVALID = rvalid;
  assign bus.RDATA  = rdata;
  assign bus.RRESP  = rresp;

  // ------------------------------------------------------------ err count
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, commit && !c_ok} + {1'b0, ar_hs && !r_ok};
  assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.AWADDR[1:0], bus.ARADDR[1:0]};

endmodule

// File: tb/tb_tpm_axil_resp_mem.sv
module tb_tpm_axil_resp_mem;
  localparam int AW    = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  tpm_axil_resp_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  tpm_axil_resp_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model: plain word array plus an error tally
  logic [31:0] ref_mem [DEPTH];
  int          ref_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_err = 0;
  endfunction

  function automatic void ref_note_err();
    if (ref_err < 255) ref_err = ref_err + 1;
  endfunction

  // returns expected BRESP
  function automatic logic [1:0] ref_write(input logic [AW-1:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    int idx;
    logic [31:0] mask;
    idx = int'(a) / 4;
    if (idx >= DEPTH) begin
      ref_note_err();
      return 2'b10;
    end
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
    return 2'b00;
  endfunction

  function automatic void ref_read(input logic [AW-1:0] a, output logic [31:0] d,
                                   output logic [1:0] r);
    int idx;
    idx = int'(a) / 4;
    if (idx >= DEPTH) begin
      d = 32'h0;
      r = 2'b10;
      ref_note_err();
    end else begin
      d = ref_mem[idx];
      r = 2'b00;
    end
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && cyc < 64) begin
      @(negedge clk);
      if (aw_done != w_done) begin
        check_eq("half_awready", 32'(bus.AWREADY), 32'(w_done));
        check_eq("half_wready", 32'(bus.WREADY), 32'(aw_done));
      end
      bus.AWADDR  = a;
      bus.AWVALID = !aw_done && cyc >= aw_dly;
      bus.WDATA   = d;
      bus.WSTRB   = s;
      bus.WVALID  = !w_done && cyc >= w_dly;
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      @(posedge clk);
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      cyc++;
    end
    check_eq("wr_handshake_timeout", 32'(aw_done && w_done), 32'd1);
    exp_resp = ref_write(a, d, s);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    check_eq("bvalid_rise", 32'(bus.BVALID), 32'd1);
    check_eq("bresp", 32'(bus.BRESP), 32'(exp_resp));
    check_eq("err_count_wr", 32'(err_count), 32'(ref_err));
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bvalid_hold", 32'(bus.BVALID), 32'd1);
      check_eq("bresp_hold", 32'(bus.BRESP), 32'(exp_resp));
      check_eq("awready_blocked", 32'(bus.AWREADY), 32'd0);
      check_eq("wready_blocked", 32'(bus.WREADY), 32'd0);
    end
    bus.BREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.BREADY = 1'b0;
    check_eq("bvalid_fall", 32'(bus.BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int r_dly);
    bit fired = 0;
    int cyc = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    while (!fired && cyc < 64) begin
      @(negedge clk);
      bus.ARADDR  = a;
      bus.ARVALID = 1'b1;
      fired = bus.ARREADY;
      @(posedge clk);
      cyc++;
    end
    check_eq("ar_handshake_timeout", 32'(fired), 32'd1);
    ref_read(a, exp_d, exp_r);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    check_eq("rvalid_rise", 32'(bus.RVALID), 32'd1);
    check_eq("rdata", bus.RDATA, exp_d);
    check_eq("rresp", 32'(bus.RRESP), 32'(exp_r));
    check_eq("err_count_rd", 32'(err_count), 32'(ref_err));
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rvalid_hold", 32'(bus.RVALID), 32'd1);
      check_eq("rdata_hold", bus.RDATA, exp_d);
      check_eq("rresp_hold", 32'(bus.RRESP), 32'(exp_r));
      check_eq("arready_blocked", 32'(bus.ARREADY), 32'd0);
    end
    bus.RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.RREADY = 1'b0;
    check_eq("rvalid_fall", 32'(bus.RVALID), 32'd0);
    check_eq("arready_back", 32'(bus.ARREADY), 32'd1);
  endtask

  // AW, W and AR all handshake on one edge, same address.
  task automatic collide(input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] exp_d;
    logic [1:0]  exp_r, exp_b;
    @(negedge clk);
    check_eq("col_awready", 32'(bus.AWREADY), 32'd1);
    check_eq("col_arready", 32'(bus.ARREADY), 32'd1);
    bus.AWADDR = a;  bus.AWVALID = 1'b1;
    bus.WDATA  = d;  bus.WSTRB   = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = a;  bus.ARVALID = 1'b1;
    ref_read(a, exp_d, exp_r);
    exp_b = ref_write(a, d, 4'hF);
    @(posedge clk);
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check_eq("col_bvalid", 32'(bus.BVALID), 32'd1);
    check_eq("col_bresp", 32'(bus.BRESP), 32'(exp_b));
    check_eq("col_rvalid", 32'(bus.RVALID), 32'd1);
    check_eq("col_rdata", bus.RDATA, exp_d);
    check_eq("col_rresp", 32'(bus.RRESP), 32'(exp_r));
    check_eq("col_err_count", 32'(err_count), 32'(ref_err));
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    check_eq("col_bvalid_fall", 32'(bus.BVALID), 32'd0);
    check_eq("col_rvalid_fall", 32'(bus.RVALID), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WSTRB  = '0; bus.WVALID  = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    ref_reset();

    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(bus.AWREADY), 32'd0);
    check_eq("rst_wready", 32'(bus.WREADY), 32'd0);
    check_eq("rst_arready", 32'(bus.ARREADY), 32'd0);
    check_eq("rst_bvalid", 32'(bus.BVALID), 32'd0);
    check_eq("rst_rvalid", 32'(bus.RVALID), 32'd0);
    check_eq("rst_rdata", bus.RDATA, 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_awready", 32'(bus.AWREADY), 32'd1);
    check_eq("post_rst_wready", 32'(bus.WREADY), 32'd1);
    check_eq("post_rst_arready", 32'(bus.ARREADY), 32'd1);

    // aligned write then read back
    for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0);

    // AW three cycles ahead of W, then W ahead of AW
    axi_write(8'h10, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    axi_read(8'h10, 0);
    axi_write(8'h1C, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    axi_read(8'h1C, 0);

    // byte strobes; unaligned address lands in the containing word
    axi_write(8'h14, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(8'h16, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(8'h14, 0);
    check_eq("strobe_model", ref_mem[5], 32'h11BB33DD);

    // out of range
    axi_write(8'h40, 32'h5555AAAA, 4'hF, 0, 0, 0);
    axi_read(8'h40, 0);
    axi_read(8'h00, 0);
    check_eq("oor_err_count", 32'(err_count), 32'd2);

    // backpressure on B and R
    axi_write(8'h0C, 32'h0BADF00D, 4'hF, 0, 0, 5);
    axi_read(8'h0C, 5);

    // same-edge commit and read, in range and out of range
    collide(8'h08, 32'h12345678);
    axi_read(8'h08, 0);
    collide(8'h44, 32'h87654321);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2));
    end

    // reset while a write is half captured
    @(negedge clk);
    bus.AWADDR = 8'h18; bus.AWVALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check_eq("half_aw_held", 32'(bus.AWREADY), 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_bvalid", 32'(bus.BVALID), 32'd0);
    check_eq("midrst_awready", 32'(bus.AWREADY), 32'd0);
    check_eq("midrst_err", 32'(err_count), 32'd0);
    ref_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("after_rst_awready", 32'(bus.AWREADY), 32'd1);
    check_eq("after_rst_wready", 32'(bus.WREADY), 32'd1);
    axi_read(8'h18, 0);
    axi_read(8'h00, 0);

    // saturate err_count
    for (int n = 0; n < 260; n++) axi_read(AW'(8'h40 + 4 * (n % 8)), 0);
    check_eq("err_saturated", 32'(err_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
